// File: rtl/spi_mem_if.sv
// spi_mem_if: SPI pins and status outputs of the SPI memory responder.
//   master modport: drives SPI_CLK, SPI_MOSI, SPI_CS_n; observes SPI_MISO and status.
//   slave  modport: observes the SPI pins; drives SPI_MISO, cmd_code, cmd_valid,
//                   wel, busy, frame_err.
interface spi_mem_if;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_CS_n;
    logic       SPI_MISO;
    logic [7:0] cmd_code;
    logic       cmd_valid;
    logic       wel;
    logic       busy;
    logic       frame_err;
    modport master (
        output SPI_CLK, SPI_MOSI, SPI_CS_n,
        input  SPI_MISO, cmd_code, cmd_valid, wel, busy, frame_err
    );
    modport slave (
        input  SPI_CLK, SPI_MOSI, SPI_CS_n,
        output SPI_MISO, cmd_code, cmd_valid, wel, busy, frame_err
    );
endinterface

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 slave emulating a byte-addressable serial memory.
//   CLKA      system clock; all SPI pins are oversampled on it (SPI_CLK <= CLKA/8)
//   rst       asynchronous active-high reset
//   bus       spi_mem_if.slave: SPI_CLK/SPI_MOSI/SPI_CS_n in, SPI_MISO out,
//             cmd_code/cmd_valid (last command byte + pulse), wel, busy, frame_err
//   Commands: READ 0x03, WRITE 0x02, RDSR 0x05, WREN 0x06, WRDI 0x04.
//   Optional macro SPI_RESP_BUSY_EN: a completed write holds busy (WIP) high for
//   BUSY_CYCLES clocks, during which only RDSR is accepted.
module spi_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int ADDR_BYTES = 3
`ifdef SPI_RESP_BUSY_EN
    ,
    parameter int BUSY_CYCLES = 64
`endif
) (
    input  logic     CLKA,
    input  logic     rst,
    spi_mem_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, STAT, IGNORE} state_t;
    state_t state_q, state_d;

    logic [2:0]    clk_s_q, cs_s_q;
    logic [1:0]    mosi_s_q;
    logic [2:0]    bit_cnt_q, abyte_q;
    logic [6:0]    rx_q;
    logic [7:0]    tx_q, cmd_code_q, rd_q, byte_val, tx_src;
    logic [AW-1:0] addr_q;
    logic          miso_q, cmd_valid_q, wel_q, wr_wel_q, frame_err_q, busy_w;
    logic          rise, fall, cs_act, cs_start, cs_end, bit_ok, byte_done, enter_cmd;
    logic          cmd_done, set_wel, clr_wel, addr_shift, ram_we, rd_next, last_abyte;
    logic [7:0]    mem_q [DEPTH];

    always_ff @(posedge CLKA or posedge rst) begin
        if (rst) begin
            clk_s_q  <= 3'b000;
            cs_s_q   <= 3'b111;
            mosi_s_q <= 2'b00;
        end else begin
            clk_s_q  <= {clk_s_q[1:0], bus.SPI_CLK};
            cs_s_q   <= {cs_s_q[1:0], bus.SPI_CS_n};
            mosi_s_q <= {mosi_s_q[0], bus.SPI_MOSI};
        end
    end

    // mosi_s_q[1] is captured in the same stage as clk_s_q[1], so it is the data bit at the rise
    assign rise       = clk_s_q[1] & ~clk_s_q[2];
    assign fall       = ~clk_s_q[1] & clk_s_q[2];
    assign cs_act     = ~cs_s_q[1];
    assign cs_start   = ~cs_s_q[1] & cs_s_q[2];
    assign cs_end     = cs_s_q[1] & ~cs_s_q[2] & (state_q != IDLE);
    assign bit_ok     = rise & ~cs_end & (state_q != IDLE);
    assign byte_done  = bit_ok & (bit_cnt_q == 3'd7);
    assign byte_val   = {rx_q, mosi_s_q[1]};
    assign enter_cmd  = (state_q == IDLE) & cs_start;
    assign last_abyte = abyte_q == 3'(ADDR_BYTES - 1);

    always_ff @(posedge CLKA or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_end)
            state_d = IDLE;
        else if (enter_cmd)
            state_d = CMD;
        else if (byte_done) begin
            case (state_q)
                CMD:     state_d = (busy_w && byte_val != OP_RDSR) ? IGNORE
                                 : (byte_val == OP_READ || byte_val == OP_WRITE) ? ADDR
                                 : (byte_val == OP_RDSR) ? STAT : IGNORE;
                ADDR:    state_d = last_abyte ? ((cmd_code_q == OP_READ) ? RD : WR) : ADDR;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cmd_done   = byte_done && state_q == CMD;
        set_wel    = cmd_done && byte_val == OP_WREN && !busy_w;
        clr_wel    = cmd_done && byte_val == OP_WRDI && !busy_w;
        addr_shift = byte_done && state_q == ADDR;
        ram_we     = byte_done && state_q == WR && wel_q;
        rd_next    = byte_done && state_q == RD;
        tx_src     = (state_q == RD) ? rd_q : (state_q == STAT) ? {6'b0, wel_q, busy_w} : 8'h00;
    end

    always_ff @(posedge CLKA or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            abyte_q     <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            cmd_code_q  <= '0;
            cmd_valid_q <= 1'b0;
            wel_q       <= 1'b0;
            wr_wel_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_done;
            if (cmd_done) cmd_code_q <= byte_val;
            if (enter_cmd) begin
                bit_cnt_q <= '0;
                abyte_q   <= '0;
                tx_q      <= '0;
                wr_wel_q  <= 1'b0;
            end else if (bit_ok) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_q      <= byte_val[6:0];
            end
            if (cmd_done) wr_wel_q <= byte_val == OP_WRITE && wel_q && !busy_w;
            if (addr_shift) begin
                abyte_q <= abyte_q + 3'd1;
                addr_q  <= AW'({addr_q, byte_val});
            end else if (ram_we || rd_next)
                addr_q <= addr_q + AW'(1);
            if (cs_end && wr_wel_q) wel_q <= 1'b0;
            else if (set_wel)       wel_q <= 1'b1;
            else if (clr_wel)       wel_q <= 1'b0;
            if (cs_end && bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
            // the fall after a byte's last rise (count back at 0) starts the next TX byte
            if (!cs_act)
                miso_q <= 1'b0;
            else if (fall) begin
                miso_q <= (bit_cnt_q == 3'd0) ? tx_src[7] : tx_q[7];
                tx_q   <= (bit_cnt_q == 3'd0) ? {tx_src[6:0], 1'b0} : {tx_q[6:0], 1'b0};
            end
        end
    end

    // write-first read port: the shared address makes a same-cycle write visible immediately
    always_ff @(posedge CLKA) begin
        if (ram_we) mem_q[addr_q] <= byte_val;
        rd_q <= ram_we ? byte_val : mem_q[addr_q];
    end

`ifdef SPI_RESP_BUSY_EN
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    logic [BW-1:0] busy_cnt_q;
    logic          wrote_q;
    always_ff @(posedge CLKA or posedge rst) begin
        if (rst) begin
            busy_cnt_q <= '0;
            wrote_q    <= 1'b0;
        end else begin
            wrote_q <= enter_cmd ? 1'b0 : (wrote_q | ram_we);
            if (cs_end && wrote_q)       busy_cnt_q <= BW'(BUSY_CYCLES);
            else if (busy_cnt_q != '0)   busy_cnt_q <= busy_cnt_q - BW'(1);
        end
    end
    assign busy_w = busy_cnt_q != '0;
`else
    assign busy_w = 1'b0;
`endif

    assign bus.SPI_MISO  = miso_q;
    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.wel       = wel_q;
    assign bus.busy      = busy_w;
    assign bus.frame_err = frame_err_q;
endmodule
